// File: rtl/particle_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : particle_pingpong_buffer
// Brief    : Double-banked particle memory. Two read-first ports on the work
//            bank, valid/ready frame stream of the display bank, and a bank
//            swap that is deferred to the frame boundary while streaming.
//            Optional macro PARTICLE_STREAM_LOOP_EN: continuous frame stream.
// Revision : 1.0 - initial release
// ============================================================================
module particle_pingpong_buffer #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  a_en_in,
    input  logic                  a_we_in,
    input  logic [ADDR_WIDTH-1:0] a_addr_in,
    input  logic [RAM_WIDTH-1:0]  a_din_in,
    output logic [RAM_WIDTH-1:0]  a_dout_out,
    input  logic                  b_en_in,
    input  logic                  b_we_in,
    input  logic [ADDR_WIDTH-1:0] b_addr_in,
    input  logic [RAM_WIDTH-1:0]  b_din_in,
    output logic [RAM_WIDTH-1:0]  b_dout_out,
    input  logic                  swap_in,
    output logic                  swap_pending_out,
    output logic                  bank_out,
    input  logic                  stream_start_in,
    output logic                  stream_busy_out,
    output logic                  stream_valid_out,
    input  logic                  stream_ready_in,
    output logic [RAM_WIDTH-1:0]  stream_data_out,
    output logic [ADDR_WIDTH-1:0] stream_addr_out,
    output logic                  stream_last_out
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Both banks live in one array; index 0/1 selects the bank.
    logic [RAM_WIDTH-1:0]  r_mem [2][RAM_DEPTH] = '{default: '0};

    logic                  r_bank;
    logic                  r_swap_pending;
    logic [RAM_WIDTH-1:0]  r_a_dout;
    logic [RAM_WIDTH-1:0]  r_b_dout;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_valid;
    logic [RAM_WIDTH-1:0]  r_rd_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr_q;

    logic [1:0]            r_sk_cnt;
    logic [RAM_WIDTH-1:0]  r_sk0_data;
    logic [RAM_WIDTH-1:0]  r_sk1_data;
    logic [ADDR_WIDTH-1:0] r_sk0_addr;
    logic [ADDR_WIDTH-1:0] r_sk1_addr;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_last_accept;
    logic [1:0]            w_cnt_next;
    logic                  w_issue;
    logic                  w_push_slot0;
    logic                  w_swap_now;

    assign w_valid       = (r_sk_cnt != 2'd0);
    assign w_pop         = w_valid && stream_ready_in;
    assign w_last        = w_valid && (r_sk0_addr == c_last_addr);
    assign w_last_accept = w_pop && w_last;
    assign w_cnt_next    = r_sk_cnt - {1'b0, w_pop} + {1'b0, r_rd_valid};
    // A new read lands one edge later; leave room for it even if nothing pops then.
    assign w_issue       = (r_state == S_RUN) && (w_cnt_next <= 2'd1);
    assign w_push_slot0  = (r_sk_cnt == {1'b0, w_pop});
    assign w_swap_now    = (r_state == S_IDLE) ? swap_in
                         : (w_last_accept && (r_swap_pending || swap_in));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (stream_start_in) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue && (r_rd_addr == c_last_addr)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_accept) begin
`ifdef PARTICLE_STREAM_LOOP_EN
                    w_state_next = S_RUN;
`else
                    w_state_next = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_rd_addr      <= '0;
            r_bank         <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next == S_RUN) && (r_state != S_RUN)) begin
                r_rd_addr <= '0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (w_swap_now) begin
                r_bank <= ~r_bank;
            end
            if ((r_state == S_IDLE) || w_last_accept) begin
                r_swap_pending <= 1'b0;
            end else if (swap_in) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // Storage is never cleared by reset. Port B is written last so it wins a collision.
    always_ff @(posedge clk_in) begin
        if (a_en_in && a_we_in) begin
            r_mem[r_bank][a_addr_in] <= a_din_in;
        end
        if (b_en_in && b_we_in) begin
            r_mem[r_bank][b_addr_in] <= b_din_in;
        end
        if (w_issue) begin
            r_rd_data   <= r_mem[~r_bank][r_rd_addr];
            r_rd_addr_q <= r_rd_addr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a_dout <= '0;
            r_b_dout <= '0;
        end else begin
            if (a_en_in) begin
                r_a_dout <= r_mem[r_bank][a_addr_in];
            end
            if (b_en_in) begin
                r_b_dout <= r_mem[r_bank][b_addr_in];
            end
        end
    end

    // Two-entry output skid; entry 0 is the presented beat.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_valid <= 1'b0;
            r_sk_cnt   <= 2'd0;
            r_sk0_data <= '0;
            r_sk1_data <= '0;
            r_sk0_addr <= '0;
            r_sk1_addr <= '0;
        end else begin
            r_rd_valid <= w_issue;
            r_sk_cnt   <= w_cnt_next;
            if (w_pop) begin
                r_sk0_data <= r_sk1_data;
                r_sk0_addr <= r_sk1_addr;
            end
            if (r_rd_valid) begin
                if (w_push_slot0) begin
                    r_sk0_data <= r_rd_data;
                    r_sk0_addr <= r_rd_addr_q;
                end else begin
                    r_sk1_data <= r_rd_data;
                    r_sk1_addr <= r_rd_addr_q;
                end
            end
        end
    end

    assign a_dout_out       = r_a_dout;
    assign b_dout_out       = r_b_dout;
    assign bank_out         = r_bank;
    assign swap_pending_out = r_swap_pending;
    assign stream_busy_out  = (r_state != S_IDLE);
    assign stream_valid_out = w_valid;
    assign stream_data_out  = r_sk0_data;
    assign stream_addr_out  = r_sk0_addr;
    assign stream_last_out  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_particle_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_particle_pingpong_buffer
// Brief    : Self-checking bench for particle_pingpong_buffer with a
//            behavioural model of both banks, the swap and the frame stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_particle_pingpong_buffer;

    localparam int W  = 18;
    localparam int D  = 8;
    localparam int AW = 3;
`ifdef PARTICLE_STREAM_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          a_en_in, a_we_in, b_en_in, b_we_in;
    logic [AW-1:0] a_addr_in, b_addr_in;
    logic [W-1:0]  a_din_in, b_din_in, a_dout_out, b_dout_out;
    logic          swap_in, swap_pending_out, bank_out;
    logic          stream_start_in, stream_busy_out, stream_valid_out;
    logic          stream_ready_in, stream_last_out;
    logic [W-1:0]  stream_data_out;
    logic [AW-1:0] stream_addr_out;

    always #5 clk_in = ~clk_in;

    particle_pingpong_buffer #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .a_en_in(a_en_in), .a_we_in(a_we_in), .a_addr_in(a_addr_in),
        .a_din_in(a_din_in), .a_dout_out(a_dout_out),
        .b_en_in(b_en_in), .b_we_in(b_we_in), .b_addr_in(b_addr_in),
        .b_din_in(b_din_in), .b_dout_out(b_dout_out),
        .swap_in(swap_in), .swap_pending_out(swap_pending_out), .bank_out(bank_out),
        .stream_start_in(stream_start_in), .stream_busy_out(stream_busy_out),
        .stream_valid_out(stream_valid_out), .stream_ready_in(stream_ready_in),
        .stream_data_out(stream_data_out), .stream_addr_out(stream_addr_out),
        .stream_last_out(stream_last_out)
    );

    logic [W-1:0] m_mem [2][D];
    logic         m_bank;
    logic         m_pending;
    logic [W-1:0] m_a_dout, m_b_dout;
    int           checks   = 0;
    int           failures = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({bank_out, swap_pending_out, stream_busy_out, stream_valid_out, stream_last_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: bank=%0b pend=%0b busy=%0b valid=%0b last=%0b, required all 0",
                     bank_out, swap_pending_out, stream_busy_out, stream_valid_out, stream_last_out);
        end
        checks++;
        if (stream_data_out !== '0 || stream_addr_out !== '0) begin
            failures++;
            $display("FAIL reset_stream: data=%0h addr=%0d, required 0/0", stream_data_out, stream_addr_out);
        end
        checks++;
        if (a_dout_out !== '0 || b_dout_out !== '0) begin
            failures++;
            $display("FAIL reset_dout: a=%0h b=%0h, required 0/0", a_dout_out, b_dout_out);
        end
        rst_in    = 1'b0;
        m_bank    = 1'b0;
        m_pending = 1'b0;
        m_a_dout  = '0;
        m_b_dout  = '0;
    endtask

    task automatic test_ab_random();
        logic          ae, aw, be, bw;
        logic [AW-1:0] aa, ba;
        logic [W-1:0]  ad, bd;
        for (int i = 0; i < 24; i++) begin
            ae = 1'($urandom_range(1, 0));
            aw = 1'($urandom_range(1, 0));
            be = 1'($urandom_range(1, 0));
            bw = 1'($urandom_range(1, 0));
            aa = AW'($urandom_range(D - 1, 0));
            ba = aa + AW'($urandom_range(D - 1, 1));
            ad = W'($urandom);
            bd = W'($urandom);
            a_en_in = ae; a_we_in = aw; a_addr_in = aa; a_din_in = ad;
            b_en_in = be; b_we_in = bw; b_addr_in = ba; b_din_in = bd;
            tick();
            if (ae) m_a_dout = m_mem[m_bank][aa];
            if (be) m_b_dout = m_mem[m_bank][ba];
            if (ae && aw) m_mem[m_bank][aa] = ad;
            if (be && bw) m_mem[m_bank][ba] = bd;
            checks++;
            if (a_dout_out !== m_a_dout || b_dout_out !== m_b_dout) begin
                failures++;
                $display("FAIL ab_random[%0d]: a=%0h b=%0h, required a=%0h b=%0h",
                         i, a_dout_out, b_dout_out, m_a_dout, m_b_dout);
            end
        end
        a_en_in = 1'b0; a_we_in = 1'b0; b_en_in = 1'b0; b_we_in = 1'b0;
    endtask

    task automatic test_ab_collision();
        logic [W-1:0] old_v;
        old_v = m_mem[m_bank][3];
        a_en_in = 1'b1; a_we_in = 1'b1; a_addr_in = 3'd3; a_din_in = 18'h1;
        b_en_in = 1'b1; b_we_in = 1'b1; b_addr_in = 3'd3; b_din_in = 18'h2;
        tick();
        m_mem[m_bank][3] = 18'h2;
        checks++;
        if (a_dout_out !== old_v || b_dout_out !== old_v) begin
            failures++;
            $display("FAIL collision_old: a=%0h b=%0h, required %0h", a_dout_out, b_dout_out, old_v);
        end
        a_we_in = 1'b0; b_en_in = 1'b0; b_we_in = 1'b0;
        tick();
        a_en_in = 1'b0;
        m_a_dout = 18'h2;
        m_b_dout = old_v;
        checks++;
        if (a_dout_out !== 18'h2) begin
            failures++;
            $display("FAIL collision_readback: a=%0h, required 2", a_dout_out);
        end
    endtask

    task automatic fill_work(input bit use_b, input bit rnd);
        logic [W-1:0] d;
        logic [W-1:0] got;
        for (int i = 0; i < D; i++) begin
            d = rnd ? W'($urandom) : W'(32'h10 + i);
            if (use_b) begin
                b_en_in = 1'b1; b_we_in = 1'b1; b_addr_in = AW'(i); b_din_in = d;
            end else begin
                a_en_in = 1'b1; a_we_in = 1'b1; a_addr_in = AW'(i); a_din_in = d;
            end
            tick();
            got = use_b ? b_dout_out : a_dout_out;
            checks++;
            if (got !== m_mem[m_bank][i]) begin
                failures++;
                $display("FAIL fill_read_first[%0d]: dout=%0h, required %0h", i, got, m_mem[m_bank][i]);
            end
            if (use_b) m_b_dout = m_mem[m_bank][i];
            else       m_a_dout = m_mem[m_bank][i];
            m_mem[m_bank][i] = d;
        end
        a_en_in = 1'b0; a_we_in = 1'b0; b_en_in = 1'b0; b_we_in = 1'b0;
    endtask

    task automatic swap_idle();
        swap_in = 1'b1;
        tick();
        swap_in = 1'b0;
        m_bank  = ~m_bank;
        checks++;
        if (bank_out !== m_bank || swap_pending_out !== 1'b0) begin
            failures++;
            $display("FAIL swap_idle: bank=%0b pend=%0b, required bank=%0b pend=0",
                     bank_out, swap_pending_out, m_bank);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1,1,0, 2 = random.
    task automatic run_stream(input int ready_mode, input int swap_k1, input int swap_k2,
                              input bit swap_with_start, input int rst_at_addr,
                              input int nframes, input string name);
        int            idx = 0;
        int            k = 0;
        int            first_valid = -1;
        int            pos;
        bit            done = 1'b0;
        bit            aborted = 1'b0;
        bit            stalled = 1'b0;
        logic          disp, r, acc, lastacc;
        logic [5:0]    pat = 6'b011001;
        logic [W-1:0]  h_data = '0;
        logic [AW-1:0] h_addr = '0;
        logic          h_last = 1'b0;

        stream_start_in = 1'b1;
        swap_in         = swap_with_start;
        stream_ready_in = 1'b0;
        if (swap_with_start) m_bank = ~m_bank;
        disp = ~m_bank;
        tick();
        stream_start_in = 1'b0;
        swap_in         = 1'b0;

        while (!done && k < 40 * D * nframes) begin
            checks++;
            if (bank_out !== m_bank || swap_pending_out !== m_pending || stream_busy_out !== 1'b1) begin
                failures++;
                $display("FAIL %s status k=%0d: bank=%0b pend=%0b busy=%0b, required bank=%0b pend=%0b busy=1",
                         name, k, bank_out, swap_pending_out, stream_busy_out, m_bank, m_pending);
            end
            if (stream_valid_out === 1'b1 && first_valid < 0) begin
                first_valid = k;
                checks++;
                if (k != 2) begin
                    failures++;
                    $display("FAIL %s first_valid: after edge T+%0d, required T+2", name, k);
                end
            end
            if (stalled) begin
                checks++;
                if (stream_valid_out !== 1'b1 || stream_data_out !== h_data ||
                    stream_addr_out !== h_addr || stream_last_out !== h_last) begin
                    failures++;
                    $display("FAIL %s stall_hold k=%0d: v=%0b d=%0h a=%0d l=%0b, required v=1 d=%0h a=%0d l=%0b",
                             name, k, stream_valid_out, stream_data_out, stream_addr_out, stream_last_out,
                             h_data, h_addr, h_last);
                end
            end
            if (rst_at_addr >= 0 && stream_valid_out === 1'b1 && stream_addr_out == AW'(rst_at_addr)) begin
                rst_in = 1'b1;
                tick();
                rst_in    = 1'b0;
                m_bank    = 1'b0;
                m_pending = 1'b0;
                aborted   = 1'b1;
                checks++;
                if (stream_valid_out !== 1'b0 || stream_busy_out !== 1'b0 ||
                    bank_out !== 1'b0 || swap_pending_out !== 1'b0) begin
                    failures++;
                    $display("FAIL %s reset_abort: valid=%0b busy=%0b bank=%0b pend=%0b, required all 0",
                             name, stream_valid_out, stream_busy_out, bank_out, swap_pending_out);
                end
                break;
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = pat[k % 6];
                default: r = 1'($urandom_range(1, 0));
            endcase
            stream_ready_in = r;
            swap_in = (k == swap_k1) || (k == swap_k2);
            acc     = (stream_valid_out === 1'b1) && r;
            lastacc = 1'b0;
            if (acc) begin
                pos = idx % D;
                checks++;
                if (stream_addr_out !== AW'(pos) || stream_data_out !== m_mem[disp][pos] ||
                    stream_last_out !== (pos == D - 1)) begin
                    failures++;
                    $display("FAIL %s beat[%0d]: addr=%0d data=%0h last=%0b, required addr=%0d data=%0h last=%0b",
                             name, idx, stream_addr_out, stream_data_out, stream_last_out,
                             pos, m_mem[disp][pos], (pos == D - 1));
                end
                lastacc = (pos == D - 1);
                idx++;
            end
            if (swap_in) m_pending = 1'b1;
            if (lastacc) begin
                if (m_pending) m_bank = ~m_bank;
                m_pending = 1'b0;
                disp = ~m_bank;
                if (idx == nframes * D) done = 1'b1;
            end
            stalled = (stream_valid_out === 1'b1) && !r;
            h_data  = stream_data_out;
            h_addr  = stream_addr_out;
            h_last  = stream_last_out;
            tick();
            k++;
        end
        stream_ready_in = 1'b0;
        swap_in         = 1'b0;

        if (!aborted) begin
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL %s timeout: %0d beats after %0d cycles, required %0d beats", name, idx, k, nframes * D);
            end
            checks++;
            if (bank_out !== m_bank || swap_pending_out !== m_pending || stream_busy_out !== LOOP ||
                (!LOOP && stream_valid_out !== 1'b0)) begin
                failures++;
                $display("FAIL %s end_state: bank=%0b pend=%0b busy=%0b valid=%0b, required bank=%0b pend=%0b busy=%0b",
                         name, bank_out, swap_pending_out, stream_busy_out, stream_valid_out,
                         m_bank, m_pending, LOOP);
            end
            if (ready_mode == 0 && nframes == 1) begin
                checks++;
                if (k != D + 2) begin
                    failures++;
                    $display("FAIL %s frame_cycles: %0d, required %0d", name, k, D + 2);
                end
            end
        end
    endtask

    initial begin
        rst_in = 1'b1;
        a_en_in = 1'b0; a_we_in = 1'b0; a_addr_in = '0; a_din_in = '0;
        b_en_in = 1'b0; b_we_in = 1'b0; b_addr_in = '0; b_din_in = '0;
        swap_in = 1'b0; stream_start_in = 1'b0; stream_ready_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < D; i++) begin
                m_mem[b][i] = '0;
            end
        end

        test_reset();
        test_ab_random();
        test_ab_collision();
`ifdef PARTICLE_STREAM_LOOP_EN
        fill_work(1'b0, 1'b0);
        swap_idle();
        fill_work(1'b1, 1'b1);
        run_stream(0, 4, -1, 1'b0, -1, 2, "loop");
        test_reset();
`else
        fill_work(1'b0, 1'b0);
        swap_idle();
        run_stream(0, -1, -1, 1'b0, -1, 1, "basic");
        run_stream(1, -1, -1, 1'b0, -1, 1, "pattern_ready");
        run_stream(2, -1, -1, 1'b0, -1, 1, "random_ready");
        fill_work(1'b1, 1'b1);
        run_stream(2, 4, 6, 1'b0, -1, 1, "swap_mid");
        run_stream(0, -1, -1, 1'b1, -1, 1, "swap_with_start");
        run_stream(0, -1, -1, 1'b0, 4, 1, "reset_mid");
        run_stream(2, -1, -1, 1'b0, -1, 1, "restream");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
